// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl_if
//  Description : EX-stage <-> multiply/divide sequencer handshake bundle.
//                master = EX stage (drives the op request, advance and flush)
//                slave  = muldiv_ctrl (drives stall/busy/done and HI/LO)
//  Signals     : op_valid, op[1:0], src_a[31:0], src_b[31:0], ex_advance,
//                flush                       (master -> slave)
//                stall_o, busy_o, done_o, hi_o[31:0], lo_o[31:0]
//                                            (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        ex_advance;
    logic        flush;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output op_valid, op, src_a, src_b, ex_advance, flush,
        input  stall_o, busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  op_valid, op, src_a, src_b, ex_advance, flush,
        output stall_o, busy_o, done_o, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
//                Latches the operands, runs either a MUL_LAT-cycle multiply
//                or a 32-step restoring divide plus sign fix-up, stalls the
//                pipeline until the 64-bit HI/LO result is ready and holds
//                it until the instruction leaves EX.
//  Parameters  : MUL_LAT  multiply pipeline cycles (1..4)
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                bus  - muldiv_ctrl_if.slave (op request in, stall/busy/
//                       done and hi/lo results out)
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    muldiv_ctrl_if.slave bus
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_MUL  = 3'd1;
    localparam logic [2:0] c_DIV  = 3'd2;
    localparam logic [2:0] c_FIX  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [4:0] c_MUL_LAST = 5'(MUL_LAT - 1);
    localparam logic [4:0] c_DIV_LAST = 5'd31;

    logic [2:0]  r_state;
    logic [2:0]  w_nextState;

    logic        r_isUnsigned;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quot;      // dividend shifts out the top, quotient in the bottom
    logic [31:0] r_divisor;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_enterDone;
    logic        w_divByZero;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [63:0] w_mulA;
    logic [63:0] w_mulB;
    logic [63:0] w_prod;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_negQuot;
    logic        w_negRem;
    logic [31:0] w_fixQuot;
    logic [31:0] w_fixRem;

    assign w_divByZero = (bus.src_b == 32'd0);
    assign w_accept    = (r_state == c_IDLE) && (w_nextState != c_IDLE);
    assign w_enterDone = (w_nextState == c_DONE) && (r_state != c_DONE);

    // Magnitudes for signed divide; -0x80000000 is 0x80000000 which is the
    // correct unsigned magnitude 2^31.
    assign w_absA = (!bus.op[0] && bus.src_a[31]) ? -bus.src_a : bus.src_a;
    assign w_absB = (!bus.op[0] && bus.src_b[31]) ? -bus.src_b : bus.src_b;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
    // correct for both signed and unsigned operands.
    assign w_mulA = {{32{!r_isUnsigned && r_a[31]}}, r_a};
    assign w_mulB = {{32{!r_isUnsigned && r_b[31]}}, r_b};
    assign w_prod = w_mulA * w_mulB;

    // One restoring step on the 33-bit partial remainder.
    assign w_shift = {r_rem, r_quot[31]};
    assign w_diff  = w_shift - {1'b0, r_divisor};

    assign w_negQuot = !r_isUnsigned && (r_a[31] ^ r_b[31]);
    assign w_negRem  = !r_isUnsigned && r_a[31];
    assign w_fixQuot = w_negQuot ? -r_quot : r_quot;
    assign w_fixRem  = w_negRem  ? -r_rem  : r_rem;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_nextState = r_state;
        if (bus.flush) begin
            w_nextState = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.op_valid) begin
                        if (!bus.op[1])       w_nextState = c_MUL;
                        else if (w_divByZero) w_nextState = c_DONE;
                        else                  w_nextState = c_DIV;
                    end
                end
                c_MUL:   if (r_cnt == c_MUL_LAST) w_nextState = c_DONE;
                c_DIV:   if (r_cnt == c_DIV_LAST) w_nextState = c_FIX;
                c_FIX:   w_nextState = c_DONE;
                c_DONE:  if (bus.ex_advance) w_nextState = c_IDLE;
                default: w_nextState = c_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        bus.stall_o = bus.op_valid && (r_state != c_DONE);
        bus.busy_o  = (r_state != c_IDLE);
        bus.done_o  = (r_state == c_DONE);
    end

    assign bus.hi_o = r_hi;
    assign bus.lo_o = r_lo;

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_isUnsigned <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quot       <= '0;
            r_divisor    <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
        end else begin
            if (w_accept) begin
                r_isUnsigned <= bus.op[0];
                r_a          <= bus.src_a;
                r_b          <= bus.src_b;
                r_cnt        <= '0;
                r_rem        <= '0;
                r_quot       <= w_absA;
                r_divisor    <= w_absB;
            end else if (r_state == c_MUL) begin
                r_cnt <= r_cnt + 5'd1;
            end else if (r_state == c_DIV) begin
                r_cnt <= r_cnt + 5'd1;
                if (!w_diff[32]) begin
                    r_rem  <= w_diff[31:0];
                    r_quot <= {r_quot[30:0], 1'b1};
                end else begin
                    r_rem  <= w_shift[31:0];
                    r_quot <= {r_quot[30:0], 1'b0};
                end
            end

            // Results only move on entry to DONE; a flush never gets here.
            if (w_enterDone) begin
                case (r_state)
                    c_IDLE: begin
                        r_hi <= bus.src_a;
                        r_lo <= 32'hFFFF_FFFF;
                    end
                    c_MUL: begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                    c_FIX: begin
                        r_hi <= w_fixRem;
                        r_lo <= w_fixQuot;
                    end
                    default: begin
                        r_hi <= r_hi;
                        r_lo <= r_lo;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_ctrl
//  Description : Self-checking bench for muldiv_ctrl: directed vector table,
//                randomized ops against an arithmetic reference model, and
//                hand-written flush / hold / back-to-back / reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 34;

    logic clk;
    logic rst;
    int   nVec;
    int   nErr;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: returns {hi, lo}.
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        if (op[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'({{32{a[31]}}, a});
            sb = longint'({{32{b[31]}}, b});
        end
        if (!op[1]) begin
            res = 64'(sa * sb);
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    function automatic int refLat(input logic [1:0] op, input logic [31:0] b);
        if (!op[1])          return MUL_LAT + 1;
        else if (b == 32'd0) return 1;
        else                 return DIV_LAT;
    endfunction

    // Called at a negedge with the DUT idle: presents the op (accept cycle t).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        #1;
        check("stallAccept", 64'(bus.stall_o), 64'(1));
        check("busyAccept", 64'(bus.busy_o), 64'(0));
    endtask

    // Waits (bounded) for done_o, checking latency, stall profile and result.
    task automatic waitDone(input string name, input int expLat,
                            input logic [31:0] expHi, input logic [31:0] expLo);
        int cyc;
        bit stallOk;
        cyc     = 0;
        stallOk = 1'b1;
        while (bus.done_o !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.done_o !== 1'b1 && bus.stall_o !== 1'b1) stallOk = 1'b0;
        end
        check({name, ".latency"}, 64'(cyc), 64'(expLat));
        check({name, ".stallHold"}, 64'(stallOk), 64'(1));
        check({name, ".stallDone"}, 64'(bus.stall_o), 64'(0));
        check({name, ".hilo"}, {bus.hi_o, bus.lo_o}, {expHi, expLo});
    endtask

    // In a DONE cycle: let the instruction leave EX, then confirm IDLE.
    task automatic releaseOp();
        bus.ex_advance = 1'b1;
        bus.op_valid   = 1'b0;
        @(negedge clk);
        bus.ex_advance = 1'b0;
        check("idleBusy", 64'(bus.busy_o), 64'(0));
        check("idleDone", 64'(bus.done_o), 64'(0));
    endtask

    vec_t vecs[10];

    initial begin
        logic [63:0] exp;
        logic [63:0] held;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          neverDone;

        nVec = 0;
        nErr = 0;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT + 1};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT + 1};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT};
        vecs[5] = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1};
        vecs[6] = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT + 1};
        vecs[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT};
        vecs[9] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MUL_LAT + 1};

        rst            = 1'b0;
        bus.op_valid   = 1'b0;
        bus.op         = 2'b00;
        bus.src_a      = '0;
        bus.src_b      = '0;
        bus.ex_advance = 1'b0;
        bus.flush      = 1'b0;

        repeat (2) @(negedge clk);
        check("rstDone", 64'(bus.done_o), 64'(0));
        check("rstBusy", 64'(bus.busy_o), 64'(0));
        check("rstStall", 64'(bus.stall_o), 64'(0));
        check("rstHiLo", {bus.hi_o, bus.lo_o}, 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone($sformatf("vec%0d", i), vecs[i].lat, vecs[i].hi, vecs[i].lo);
            releaseOp();
        end

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp = refModel(rop, ra, rb);
            issue(rop, ra, rb);
            waitDone($sformatf("rnd%0d", i), refLat(rop, rb), exp[63:32], exp[31:0]);
            releaseOp();
        end

        // Flush in cycle t+10 of a divide.
        issue(2'b10, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        bus.flush    = 1'b1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flushBusy", 64'(bus.busy_o), 64'(0));
        check("flushDone", 64'(bus.done_o), 64'(0));
        neverDone = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0) neverDone = 1'b0;
        end
        check("flushNoDone", 64'(neverDone), 64'(1));
        issue(2'b00, 32'hFFFF_FFFB, 32'd9);
        waitDone("postFlushMult", MUL_LAT + 1, 32'hFFFF_FFFF, 32'hFFFF_FFD3);
        releaseOp();

        // Hold DONE for 5 cycles, then back-to-back op with op_valid high
        // during the ex_advance cycle.
        issue(2'b11, 32'd100, 32'd7);
        waitDone("holdDivu", DIV_LAT, 32'd2, 32'd14);
        held = {bus.hi_o, bus.lo_o};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("holdDone", 64'(bus.done_o), 64'(1));
            check("holdStall", 64'(bus.stall_o), 64'(0));
            check("holdHiLo", {bus.hi_o, bus.lo_o}, held);
        end
        bus.ex_advance = 1'b1;
        bus.op         = 2'b01;
        bus.src_a      = 32'd6;
        bus.src_b      = 32'd7;
        #1;
        check("advStall", 64'(bus.stall_o), 64'(0));
        @(negedge clk);
        bus.ex_advance = 1'b0;
        check("b2bBusy", 64'(bus.busy_o), 64'(0));
        check("b2bStall", 64'(bus.stall_o), 64'(1));
        check("b2bHiLoHeld", {bus.hi_o, bus.lo_o}, held);
        waitDone("b2bMultu", MUL_LAT + 1, 32'd0, 32'd42);
        releaseOp();

        // Asynchronous reset mid-divide, op_valid left high.
        issue(2'b11, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arstBusy", 64'(bus.busy_o), 64'(0));
        check("arstDone", 64'(bus.done_o), 64'(0));
        check("arstHiLo", {bus.hi_o, bus.lo_o}, 64'(0));
        check("arstStall", 64'(bus.stall_o), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        exp = refModel(2'b11, 32'hDEAD_BEEF, 32'h0000_1234);
        #1;
        check("reacceptStall", 64'(bus.stall_o), 64'(1));
        waitDone("reaccept", DIV_LAT, exp[63:32], exp[31:0]);
        releaseOp();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
- Accepts a HI/LO arithmetic op from the EX stage, iterates a shared multiplier/divider datapath, and holds the pipeline via `stall_o` until the 64-bit result is ready.
- Returns `hi_o`/`lo_o` for the HI/LO write path, then frees itself when the instruction leaves EX.
- Sits beside the ALU; its op select is derived from the decoded `ALUCtrl` MULT/MULTU/DIV/DIVU codes.

## Interface
Parameters:
- `MUL_LAT`, default 2: multiply pipeline cycles, legal range 1..4.

Ports:
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset (0 = reset).
- `op_valid`  in  1: EX holds a muldiv op; level signal, stable while `stall_o`=1.
- `op`  in  2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  32: rs value (multiplicand / dividend).
- `src_b`  in  32: rt value (multiplier / divisor).
- `ex_advance`  in  1: EX instruction moves to MEM this cycle.
- `flush`  in  1: synchronous cancel (exception/ERET in a later stage).
- `stall_o`  out  1: hold IF/ID/EX.
- `busy_o`  out  1: state ≠ IDLE.
- `done_o`  out  1: `hi_o`/`lo_o` valid.
- `hi_o`  out  32: HI result (product[63:32] / remainder).
- `lo_o`  out  32: LO result (product[31:0] / quotient).

## Operation
States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - `op_valid`=1 accepts the op and latches operands.
  - op[1]=0: go to MUL.
  - op[1]=1 and `src_b`≠0: go to DIV, loading |a| and |b| (signed) or raw values (unsigned).
  - op[1]=1 and `src_b`=0: go directly to DONE with hi=`src_a`, lo=32'hFFFFFFFF, signed and unsigned alike.
- MUL:
  - Counts `MUL_LAT` cycles, then goes to DONE.
  - Product is the 64-bit signed (MULT) or unsigned (MULTU) a×b.
- DIV:
  - 32 restoring radix-2 iterations, one per cycle, on a 33-bit partial remainder and a 5-bit counter.
  - After iteration 32, go to FIX.
- FIX:
  - Signed only: negate quotient if sign(a)≠sign(b); negate remainder if a<0.
  - Unsigned: pass through.
  - Go to DONE.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (two's-complement wrap, no trap).
- DONE:
  - `done_o`=1; results held.
  - `ex_advance`=1: go to IDLE.
  - A new `op_valid` in the same cycle is not accepted; it is accepted in the next IDLE cycle.
- Outputs:
  - `stall_o` = `op_valid` & (state ≠ DONE). It is combinational, so it is high in the accept cycle itself.
  - `busy_o` = (state ≠ IDLE).
- `flush`=1 in any state: next state IDLE, `done_o` low next cycle, results discarded. `flush` has priority over accept and `ex_advance`.
- `op`, `src_a` and `src_b` are ignored outside IDLE; latched copies are used.

## Timing
Reset (`rst`=0, asynchronous):
- state = IDLE.
- `done_o`=0, `busy_o`=0, `hi_o`=0, `lo_o`=0.
- `stall_o`=0 unless `op_valid` is high.
- Internal counters and registers cleared.

Accept in cycle t. `done_o` first goes high in:
- Multiply: cycle t+MUL_LAT+1 (MUL occupies t+1..t+MUL_LAT).
- Divide: cycle t+34 (DIV t+1..t+32, FIX t+33).
- Divide by zero: cycle t+1.

Other timing rules:
- `stall_o` is high from cycle t through the last cycle before DONE, and low from the first DONE cycle.
- `hi_o`/`lo_o` change only on entry to DONE, and otherwise hold their last value (including after IDLE return).
- Reset asserted mid-operation: immediate IDLE, no result. `op_valid` still high after reset is re-accepted as a fresh op.
- Back-to-back ops:
  - `ex_advance` in DONE cycle d returns to IDLE at d+1.
  - The next op is accepted at d+1 at the earliest; `stall_o` is high from d+1.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, MUL_LAT=2, accept at t:
  - `stall_o` high t..t+2.
  - `done_o` at t+3, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3, b=7:
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2, accept at t:
  - `done_o` at t+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7:
  - lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF:
  - lo=0x80000000, hi=0.
- DIVU b=0, a=0x1234:
  - `done_o` at t+1, hi=0x1234, lo=0xFFFFFFFF.
  - `stall_o` high only in cycle t.
- `flush` at t+10 of a DIV:
  - IDLE at t+11, `done_o` never asserts, `busy_o`=0 at t+11.
  - Subsequent MULT completes normally.
- `ex_advance` held low 5 cycles in DONE:
  - `done_o` and results stable, no re-accept.
  - Asserting `ex_advance` returns to IDLE; next op is accepted the following cycle.
- Async reset pulse mid-DIV:
  - All outputs 0 within the reset, no clock edge needed.
